hybridcore_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding hybridcore_processor.instruction. Holds the PC, reads 32-bit words

---
 rtl/hybridcore_pkg.sv | 14 +
 rtl/hybridcore_fetch_fifo.sv | 54 +++++
 rtl/hybridcore_fetch_unit.sv | 88 ++++++++
 tb/tb_hybridcore_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hybridcore_pkg.sv
// Shared types and constants for the hybridcore fetch stage.
package hybridcore_pkg;

    localparam int INSTR_W   = 32;
    localparam int HC_ADDR_W = 32;

    localparam logic [INSTR_W-1:0] HC_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0]   instr;
        logic [HC_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/hybridcore_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; the head is read straight from the storage registers.
module hybridcore_fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush wins over push/pop; a pop of the head in the flush cycle has already been seen by the consumer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/hybridcore_fetch_unit.sv
// Fetch stage: PC, credit-based issue to a 1-cycle synchronous imem, prefetch FIFO, redirect flush.
module hybridcore_fetch_unit
    import hybridcore_pkg::*;
#(
    parameter int                  ADDR_W   = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter logic [INSTR_W-1:0]  NOP      = HC_NOP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [ADDR_W-1:0]   instr_pc
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int USE_W   = CNT_W + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic               head_valid;
    logic [ENTRY_W-1:0] head_data;
    logic [USE_W-1:0]   used;
    logic [ADDR_W-1:0]  redirect_aligned;
    logic               issue;
    logic               push;
    logic               pop;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    // Occupancy at the start of the cycle plus the outstanding read; a same-cycle pop frees nothing.
    assign used  = {1'b0, fifo_count} + USE_W'(inflight);
    assign issue = fetch_en && !rst && !redirect_valid && (used < USE_W'(DEPTH));

    // A read landing in a redirect cycle belongs to the old path and is dropped here.
    assign push = inflight && !redirect_valid && !rst;
    assign pop  = head_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc       <= redirect_aligned;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + ADDR_W'(4);
                inflight_pc <= pc;
            end
        end
    end

    hybridcore_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_data  ({imem_rdata, inflight_pc}),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign imem_en     = issue;
    assign imem_addr   = pc;
    assign instr_valid = head_valid;
    assign instr_out   = head_valid ? head_data[ENTRY_W-1 -: INSTR_W] : NOP;
    assign instr_pc    = head_valid ? head_data[ADDR_W-1:0] : RESET_PC;

endmodule

// File: tb/tb_hybridcore_fetch_unit.sv
// Bench for hybridcore_fetch_unit: directed literal checks plus randomized traffic against a queue model.
module tb_hybridcore_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_fifo[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_pc = 32'h0;

    hybridcore_fetch_unit #(
        .ADDR_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .NOP      (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h00:  return 32'h0641_0005;
            32'h04:  return 32'h0642_0003;
            32'h08:  return 32'h0443_0002;
            32'h0C:  return 32'h0544_0004;
            32'h10:  return 32'h0651_2000;
            default: return (addr * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-level model: what the consumer must see, and when a read may be issued.
    always @(negedge clk) begin
        if (model_on) begin
            bit   exp_valid;
            bit   exp_en;
            ent_t e;
            exp_valid = (m_fifo.size() != 0);
            exp_en = fetch_en && !rst && !redirect_valid && ((m_fifo.size() + m_pend.size()) < DEPTH);
            check("model_valid", instr_valid, exp_valid);
            if (exp_valid) begin
                check("model_instr", instr_out, m_fifo[0].instr);
                check("model_pc", instr_pc, m_fifo[0].pc);
            end else begin
                check("model_nop", instr_out, 32'h0);
            end
            check("model_imem_en", imem_en, exp_en);
            check("model_imem_addr", imem_addr, m_pc);
            if (rst) begin
                m_fifo.delete();
                m_pend.delete();
                m_pc = 32'h0;
            end else begin
                if (exp_valid && instr_ready) void'(m_fifo.pop_front());
                if (redirect_valid) begin
                    m_fifo.delete();
                    m_pend.delete();
                    m_pc = redirect_pc & ~32'h3;
                end else begin
                    if (m_pend.size() != 0) begin
                        e.pc = m_pend[0];
                        e.instr = mem_word(m_pend[0]);
                        m_fifo.push_back(e);
                    end
                    m_pend.delete();
                    if (exp_en) begin
                        m_pend.push_back(m_pc);
                        m_pc = m_pc + 32'h4;
                    end
                end
            end
        end
    end

    task automatic applyStimulus();
        rst = ($urandom_range(0, 199) == 0);
        fetch_en = ($urandom_range(0, 9) != 0);
        instr_ready = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        else redirect_pc = $urandom & 32'h0000_0FFF;
    endtask

    task automatic checkOutput(input string name, input logic v, input logic [31:0] pc, input logic [31:0] word);
        check({name, "_valid"}, instr_valid, v);
        if (v) begin
            check({name, "_pc"}, instr_pc, pc);
            check({name, "_instr"}, instr_out, word);
        end else begin
            check({name, "_nop"}, instr_out, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] lin_words[5];
        int          lat;
        lin_words[0] = 32'h0641_0005;
        lin_words[1] = 32'h0642_0003;
        lin_words[2] = 32'h0443_0002;
        lin_words[3] = 32'h0544_0004;
        lin_words[4] = 32'h0651_2000;

        @(posedge clk); #1;
        model_on = 1'b1;
        @(negedge clk);
        checkOutput("reset", 1'b0, 32'h0, 32'h0);
        check("reset_imem_en", imem_en, 32'h0);
        check("reset_imem_addr", imem_addr, 32'h0);

        // Linear fetch: first valid two cycles after the first read.
        @(posedge clk); #1;
        rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        check("lin_first_en", imem_en, 32'h1);
        check("lin_first_addr", imem_addr, 32'h0);
        lat = 0;
        while (!instr_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("lin_latency", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("lin", 1'b1, 32'(i * 4), lin_words[i]);
            @(negedge clk);
        end

        // Redirect to a misaligned target: aligned fetch restarts the cycle after the pulse.
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h21;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_addr", imem_addr, 32'h20);
        check("redir_en", imem_en, 32'h1);
        checkOutput("redir_r1", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("redir_r2", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("redir_r3", 1'b1, 32'h20, mem_word(32'h20));

        // Backpressure until full, then reset with a full FIFO.
        @(posedge clk); #1;
        instr_ready = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("full_imem_en", imem_en, 32'h0);
        check("full_valid", instr_valid, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_full", 1'b0, 32'h0, 32'h0);
        check("rst_full_addr", imem_addr, 32'h0);

        // fetch_en low: everything drains, then stays idle.
        @(posedge clk); #1;
        fetch_en = 1'b0; instr_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_valid", instr_valid, 32'h0);
        check("drain_imem_en", imem_en, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            applyStimulus();
        end
        @(posedge clk); #1;
        rst = 1'b0; redirect_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
